// File: rtl/mips_alu_arbiter.sv
// mips_alu_arbiter: round-robin share of one single-cycle MIPS ALU between two
// requesters, with a held per-port response register. Rev 1.0
`default_nettype none

module mips_alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_srca_i,
    input  logic [WIDTH-1:0] req0_srcb_i,
    input  logic [2:0]       req0_ctrl_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_srca_i,
    input  logic [WIDTH-1:0] req1_srcb_i,
    input  logic [2:0]       req1_ctrl_i,

    output logic [WIDTH-1:0] alu_srca_o,
    output logic [WIDTH-1:0] alu_srcb_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_zero_i,

    output logic             rsp0_valid_o,
    input  logic             rsp0_ready_i,
    output logic [WIDTH-1:0] rsp0_result_o,
    output logic             rsp0_zero_o,

    output logic             rsp1_valid_o,
    input  logic             rsp1_ready_i,
    output logic [WIDTH-1:0] rsp1_result_o,
    output logic             rsp1_zero_o,

    output logic             busy_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             last_q;
    logic             port_q;
    logic [WIDTH-1:0] srca_q, srcb_q;
    logic [2:0]       ctrl_q;
    logic             rsp0_valid_q, rsp1_valid_q;
    logic [WIDTH-1:0] rsp0_result_q, rsp1_result_q;
    logic             rsp0_zero_q, rsp1_zero_q;

    logic elig0, elig1, grant_any, grant_sel, handshake;

    // A port whose response is being consumed this cycle may be refilled at once.
    always_comb begin
        elig0     = req0_valid_i & (~rsp0_valid_q | rsp0_ready_i);
        elig1     = req1_valid_i & (~rsp1_valid_q | rsp1_ready_i);
        grant_any = elig0 | elig1;
        grant_sel = (elig0 & elig1) ? ~last_q : elig1;
        handshake = (state_q == ST_IDLE) & grant_any;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_any) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q == ST_EXEC);
        req0_ready_o = (state_q == ST_IDLE) & grant_any & ~grant_sel;
        req1_ready_o = (state_q == ST_IDLE) & grant_any &  grant_sel;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
            port_q <= 1'b0;
            srca_q <= '0;
            srcb_q <= '0;
            ctrl_q <= 3'b000;
        end else if (handshake) begin
            last_q <= grant_sel;
            port_q <= grant_sel;
            srca_q <= grant_sel ? req1_srca_i : req0_srca_i;
            srcb_q <= grant_sel ? req1_srcb_i : req0_srcb_i;
            ctrl_q <= grant_sel ? req1_ctrl_i : req0_ctrl_i;
        end
    end

    // Capture takes priority over consumption at the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_zero_q   <= 1'b0;
        end else begin
            if (state_q == ST_EXEC && !port_q) begin
                rsp0_valid_q  <= 1'b1;
                rsp0_result_q <= alu_result_i;
                rsp0_zero_q   <= alu_zero_i;
            end else if (rsp0_valid_q && rsp0_ready_i) begin
                rsp0_valid_q  <= 1'b0;
            end
            if (state_q == ST_EXEC && port_q) begin
                rsp1_valid_q  <= 1'b1;
                rsp1_result_q <= alu_result_i;
                rsp1_zero_q   <= alu_zero_i;
            end else if (rsp1_valid_q && rsp1_ready_i) begin
                rsp1_valid_q  <= 1'b0;
            end
        end
    end

    assign alu_srca_o    = srca_q;
    assign alu_srcb_o    = srcb_q;
    assign alu_ctrl_o    = ctrl_q;
    assign rsp0_valid_o  = rsp0_valid_q;
    assign rsp0_result_o = rsp0_result_q;
    assign rsp0_zero_o   = rsp0_zero_q;
    assign rsp1_valid_o  = rsp1_valid_q;
    assign rsp1_result_o = rsp1_result_q;
    assign rsp1_zero_o   = rsp1_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_alu_arbiter.sv
// tb_mips_alu_arbiter: directed stimulus with a queue scoreboard per response port.
`default_nettype none

module tb_mips_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
    logic [2:0]       req0_ctrl, req1_ctrl;
    logic [WIDTH-1:0] alu_srca, alu_srcb, alu_res;
    logic [2:0]       alu_ctrl;
    logic             alu_zero;
    logic             rsp0_valid, rsp0_ready, rsp0_zero;
    logic             rsp1_valid, rsp1_ready, rsp1_zero;
    logic [WIDTH-1:0] rsp0_result, rsp1_result;
    logic             busy;

    logic [WIDTH:0] q0[$];
    logic [WIDTH:0] q1[$];

    int s_checks = 0, s_fails = 0;
    int m_checks = 0, m_fails = 0;

    always #5 clk = ~clk;

    mips_alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_srca_i(req0_srca), .req0_srcb_i(req0_srcb), .req0_ctrl_i(req0_ctrl),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_srca_i(req1_srca), .req1_srcb_i(req1_srcb), .req1_ctrl_i(req1_ctrl),
        .alu_srca_o(alu_srca), .alu_srcb_o(alu_srcb), .alu_ctrl_o(alu_ctrl),
        .alu_result_i(alu_res), .alu_zero_i(alu_zero),
        .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
        .rsp0_result_o(rsp0_result), .rsp0_zero_o(rsp0_zero),
        .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
        .rsp1_result_o(rsp1_result), .rsp1_zero_o(rsp1_zero),
        .busy_o(busy)
    );

    // Single-cycle MIPS ALU seen by the arbiter.
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            3'b000: alu_res = alu_srca & alu_srcb;
            3'b001: alu_res = alu_srca | alu_srcb;
            3'b010: alu_res = alu_srca + alu_srcb;
            3'b100: alu_res = alu_srca - alu_srcb;
            3'b101: alu_res = alu_srca * alu_srcb;
            3'b110: alu_res = {{(WIDTH-1){1'b0}}, ($signed(alu_srca) < $signed(alu_srcb))};
            default: alu_res = '0;
        endcase
        alu_zero = (alu_res == '0);
    end

    // Monitor: compare every consumed response against the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid && rsp0_ready) begin
                m_checks++;
                if (q0.size() == 0) begin
                    m_fails++;
                    $display("FAIL rsp0_unexpected got result=%h zero=%0d", rsp0_result, rsp0_zero);
                end else begin
                    logic [WIDTH:0] e0;
                    e0 = q0.pop_front();
                    if ({rsp0_zero, rsp0_result} !== e0) begin
                        m_fails++;
                        $display("FAIL rsp0 got zero=%0d result=%h exp zero=%0d result=%h",
                                 rsp0_zero, rsp0_result, e0[WIDTH], e0[WIDTH-1:0]);
                    end
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                m_checks++;
                if (q1.size() == 0) begin
                    m_fails++;
                    $display("FAIL rsp1_unexpected got result=%h zero=%0d", rsp1_result, rsp1_zero);
                end else begin
                    logic [WIDTH:0] e1;
                    e1 = q1.pop_front();
                    if ({rsp1_zero, rsp1_result} !== e1) begin
                        m_fails++;
                        $display("FAIL rsp1 got zero=%0d result=%h exp zero=%0d result=%h",
                                 rsp1_zero, rsp1_result, e1[WIDTH], e1[WIDTH-1:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        s_checks++;
        if (act !== exp) begin
            s_fails++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic issue(input bit port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] c, input logic [WIDTH-1:0] res, input logic z,
                         input bit push);
        bit done;
        done = 1'b0;
        if (!port) begin req0_valid = 1'b1; req0_srca = a; req0_srcb = b; req0_ctrl = c; end
        else       begin req1_valid = 1'b1; req1_srca = a; req1_srcb = b; req1_ctrl = c; end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if ((!port && req0_ready) || (port && req1_ready)) begin
                done = 1'b1;
                if (push) begin
                    if (!port) q0.push_back({z, res});
                    else       q1.push_back({z, res});
                end
            end
            step();
        end
        if (!port) req0_valid = 1'b0; else req1_valid = 1'b0;
        if (!done) begin
            s_checks++; s_fails++;
            $display("FAIL issue_timeout port=%0d", port);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !busy) done = 1'b1;
        end
        step();
        if (!done) begin
            s_checks++; s_fails++;
            $display("FAIL drain_timeout q0=%0d q1=%0d", q0.size(), q1.size());
        end
    endtask

    initial begin
        int g1, gcount;
        req0_valid = 0; req1_valid = 0;
        req0_srca = '0; req0_srcb = '0; req0_ctrl = 3'b000;
        req1_srca = '0; req1_srcb = '0; req1_ctrl = 3'b000;
        rsp0_ready = 1; rsp1_ready = 1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        req0_valid = 1'b1;

        // Reset values; ready follows the combinational rule under reset.
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 0);
        chk("rst_rsp0_result", rsp0_result, 0);
        chk("rst_rsp_zero", {30'b0, rsp1_zero, rsp0_zero}, 0);
        chk("rst_alu_srca", alu_srca, 0);
        chk("rst_alu_ctrl", {29'b0, alu_ctrl}, 0);
        chk("rst_req_ready", {30'b0, req1_ready, req0_ready}, 32'h1);
        req0_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Single ADD: latency check.
        req0_valid = 1; req0_srca = 5; req0_srcb = 7; req0_ctrl = 3'b010;
        @(negedge clk);
        chk("add_ready_t0", {31'b0, req0_ready}, 1);
        q0.push_back({1'b0, 32'd12});
        step();
        req0_valid = 0;
        @(negedge clk);
        chk("add_busy_t1", {31'b0, busy}, 1);
        @(negedge clk);
        chk("add_rsp0_valid_t2", {31'b0, rsp0_valid}, 1);
        chk("add_rsp0_result_t2", rsp0_result, 32'd12);
        step();
        drain();

        // Back-pressure on port 0 while port 1 is served.
        rsp0_ready = 0;
        issue(0, 32'hF0, 32'h0F, 3'b001, 32'hFF, 1'b0, 1);
        step();
        req0_valid = 1; req0_srca = 2; req0_srcb = 2; req0_ctrl = 3'b010;
        req1_valid = 1; req1_srca = 6; req1_srcb = 7; req1_ctrl = 3'b101;
        g1 = 0;
        for (int i = 0; i < 6; i++) begin
            bit g;
            @(negedge clk);
            chk("bp_req0_ready", {31'b0, req0_ready}, 0);
            chk("bp_rsp0_hold", rsp0_result, 32'hFF);
            g = req1_ready;
            if (g) begin g1++; q1.push_back({1'b0, 32'd42}); end
            step();
            if (g) req1_valid = 0;
        end
        chk("bp_port1_grants", g1, 1);
        rsp0_ready = 1;
        @(negedge clk);
        chk("bp_release_ready", {31'b0, req0_ready}, 1);
        if (req0_ready) q0.push_back({1'b0, 32'd4});
        step();
        req0_valid = 0;
        drain();

        // Consume-and-refill in the same IDLE cycle.
        rsp0_ready = 0;
        issue(0, 32'd1, 32'd2, 3'b010, 32'd3, 1'b0, 1);
        step();
        rsp0_ready = 1;
        req0_valid = 1; req0_srca = 32'hC; req0_srcb = 32'hA; req0_ctrl = 3'b000;
        @(negedge clk);
        chk("refill_rsp0_valid", {31'b0, rsp0_valid}, 1);
        chk("refill_ready", {31'b0, req0_ready}, 1);
        q0.push_back({1'b0, 32'h8});
        step();
        req0_valid = 0;
        @(negedge clk);
        chk("refill_busy", {31'b0, busy}, 1);
        @(negedge clk);
        chk("refill_rsp0_valid2", {31'b0, rsp0_valid}, 1);
        chk("refill_rsp0_result", rsp0_result, 32'h8);
        step();
        drain();

        // Unused control code is captured as a normal response.
        issue(1, 32'd3, 32'd4, 3'b111, 32'd0, 1'b1, 1);
        drain();

        // Reset during EXEC drops the operation.
        issue(0, 32'd1, 32'd1, 3'b010, 32'd2, 1'b0, 0);
        chk("mid_busy_before", {31'b0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_alu_srca", alu_srca, 0);
        chk("mid_rst_alu_srcb", alu_srcb, 0);
        chk("mid_rst_rsp1_result", rsp1_result, 0);
        chk("mid_rst_rsp1_zero", {31'b0, rsp1_zero}, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", {30'b0, rsp1_valid, rsp0_valid}, 0);
        end
        step();

        // Tie round-robin; the pointer was just reset so port 0 wins first.
        req0_valid = 1; req0_srca = 9; req0_srcb = 9; req0_ctrl = 3'b100;
        req1_valid = 1; req1_srca = 3; req1_srcb = 4; req1_ctrl = 3'b110;
        gcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) begin
                s_checks++; s_fails++;
                $display("FAIL tie_both_ready cycle=%0d", i);
            end else if (req0_ready || req1_ready) begin
                chk("tie_grant_port", {31'b0, req1_ready}, gcount % 2);
                if (req1_ready) q1.push_back({1'b0, 32'd1});
                else            q0.push_back({1'b1, 32'd0});
                gcount++;
            end
        end
        step();
        req0_valid = 0; req1_valid = 0;
        chk("tie_grant_count", gcount, 4);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", s_checks + m_checks, s_fails + m_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_alu_arbiter.md
# mips_alu_arbiter

Shares the single-cycle MIPS ALU between two requesters: port 0 (pipeline execute stage) and port 1 (auxiliary address/compare unit). It arbitrates round-robin, registers the granted operands into the ALU, and captures result and zero flag into a per-port response register. Each response register is held until its requester accepts it. It sits between the requesters and the ALU instance, and owns the ALU's SrcA/SrcB/ALUControl inputs.

## Interface
- WIDTH, 32, operand/result width; must match the ALU width.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-low reset.
- REQ0_VALID / REQ1_VALID  in  1  request present on port n.
- REQ0_READY / REQ1_READY  out  1  request accepted this cycle when VALID&READY.
- REQ0_SRCA / REQ1_SRCA  in  WIDTH  operand A.
- REQ0_SRCB / REQ1_SRCB  in  WIDTH  operand B.
- REQ0_CTRL / REQ1_CTRL  in  3  ALU control code (000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT).
- ALU_SRCA / ALU_SRCB  out  WIDTH  registered operands to the ALU.
- ALU_CTRL  out  3  registered control code to the ALU.
- ALU_RESULT  in  WIDTH  ALU combinational result.
- ALU_ZERO  in  1  ALU zero flag.
- RSP0_VALID / RSP1_VALID  out  1  response held for port n.
- RSP0_READY / RSP1_READY  in  1  requester consumes the response.
- RSP0_RESULT / RSP1_RESULT  out  WIDTH  captured result.
- RSP0_ZERO / RSP1_ZERO  out  1  captured zero flag.
- BUSY  out  1  high while in EXEC.

## Operation
- Two-state FSM: IDLE, EXEC.
- Port n is eligible in IDLE when REQn_VALID=1 and (RSPn_VALID=0 or RSPn_READY=1).
- Grant:
  - Only one eligible port: that port is granted.
  - Both eligible: the port not granted last wins.
  - The last-grant pointer resets to 1, so port 0 wins the first tie.
- REQn_READY is asserted combinationally only in IDLE, only for the granted port. It is 0 in EXEC.
- On handshake:
  - Latch SRCA, SRCB and CTRL into ALU_SRCA/ALU_SRCB/ALU_CTRL.
  - Record the granted port and update the last-grant pointer.
  - Go to EXEC.
- EXEC, always exactly one cycle:
  - At its closing edge, capture ALU_RESULT/ALU_ZERO into RSPn_RESULT/RSPn_ZERO of the recorded port and set RSPn_VALID.
  - Return to IDLE.
- RSPn_VALID clears at the edge where RSPn_VALID&RSPn_READY, unless a capture to the same port occurs at that same edge; capture wins.
- RSPn_RESULT/ZERO are stable while RSPn_VALID=1 and not yet consumed.
- ALU_* outputs hold their last latched values in IDLE.
- Control codes 011 and 111 are passed through unchanged. The ALU returns 0 and zero=1, and that is captured as a normal response.
- No arithmetic is performed in this block; widths pass straight through.

## Timing
- Reset (RST=0, asynchronous): FSM=IDLE, last-grant=1, ALU_SRCA/ALU_SRCB=0, ALU_CTRL=000, RSPn_VALID=0, RSPn_RESULT=0, RSPn_ZERO=0, BUSY=0.
- REQn_READY under reset follows the combinational rule with RSPn_VALID=0.
- Reset during EXEC drops the in-flight operation; no response is produced.
- Latency: a handshake in cycle t gives EXEC in cycle t+1 and RSPn_VALID=1 in cycle t+2.
- Throughput: one operation per 2 cycles. A new grant is possible in cycle t+2.
- Back-pressure: while RSPn_VALID=1 and RSPn_READY=0, port n is never granted. The other port keeps being served.
- Responses from the two ports are independent; both may be valid simultaneously.

## Test plan
- Single ADD: port0 issues A=5, B=7, CTRL=010 at t=0. Expect REQ0_READY=1 at t=0, BUSY=1 at t=1, RSP0_VALID=1 with RESULT=12, ZERO=0 at t=2.
- Tie round-robin: both ports continuously valid, RSP_READY=1 (port0 SUB 9-9, port1 SLT 3<4). Expect grants 0,1,0,1 every 2 cycles; RSP0 RESULT=0, ZERO=1; RSP1 RESULT=1, ZERO=0.
- Back-pressure: RSP0_READY=0 after the first port0 response (OR 0xF0|0x0F=0xFF). Port0 is never granted again and RSP0_RESULT holds 0xFF; port1 MUL 6*7 completes with 42. Raising RSP0_READY re-enables port0 in the same cycle.
- Consume-and-refill: RSP0_VALID=1 with RSP0_READY=1 in the same IDLE cycle as a new port0 AND 0xC&0xA. Expect the grant that cycle and RSP0_RESULT=0x8 two cycles later with no gap in RSP0_VALID handling.
- Reset mid-EXEC: assert RST=0 during EXEC of ADD 1+1. All outputs return to reset values immediately, and no RSP_VALID follows after release.
- Invalid code: port1 CTRL=111, A=3, B=4. Expect RSP1_VALID with RESULT=0, ZERO=1.
